// File: rtl/gvp_nd_if.sv
// Bus bundle for the gvp_nd vector sequencer: program/control inputs and axis stream outputs.
// Compile-time option GVP_ND_SATURATE_EN lives in gvp_nd.sv; this bundle is unaffected by it.
interface gvp_nd_if #(
  parameter int NAXES = 6,
  parameter int AXW   = 32,
  parameter int TIMEW = 48
);
  logic                     setvec;
  logic [32*(7+NAXES)-1:0]  vp_set;
  logic [31:0]              reset_options;
  logic                     pause;

  // Streams carry no ready: every beat flagged by store_data while tvalid=1 must be
  // consumed on that clock; tvalid only qualifies tdata/index/time as belonging to a live run.
  logic [NAXES*AXW-1:0]     M_AXIS_tdata;
  logic                     M_AXIS_tvalid;
  logic [31:0]              M_AXIS_index_tdata;
  logic [TIMEW-1:0]         M_AXIS_gvp_time_tdata;
  logic [31:0]              options;
  logic [1:0]               store_data;
  logic                     gvp_finished;
  logic [2:0]               dbg_state;

  modport master (
    output setvec, vp_set, reset_options, pause,
    input  M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_index_tdata, M_AXIS_gvp_time_tdata,
           options, store_data, gvp_finished, dbg_state
  );

  modport slave (
    input  setvec, vp_set, reset_options, pause,
    output M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_index_tdata, M_AXIS_gvp_time_tdata,
           options, store_data, gvp_finished, dbg_state
  );
endinterface

// File: rtl/gvp_nd.sv
// N-axis generalised vector program sequencer with per-vector repeat loops.
// Define GVP_ND_SATURATE_EN to clamp accumulators instead of wrapping.
module gvp_nd #(
  parameter int NAXES  = 6,
  parameter int AXW    = 32,
  parameter int VADR_W = 4,
  parameter int TIMEW  = 48
) (
  input logic     a_clk,
  input logic     reset,
  gvp_nd_if.slave bus
);
  localparam int VDEPTH = 1 << VADR_W;
  localparam int NW     = 7 + NAXES;

  typedef enum logic [2:0] {IDLE, LOAD, HDR, STEP, FIN} state_t;

  state_t state, state_n;

  logic [31:0]    w [NW];
  logic [31:0]    mem_n     [VDEPTH];
  logic [31:0]    mem_nii   [VDEPTH];
  logic [31:0]    mem_opt   [VDEPTH];
  logic [31:0]    mem_nrep  [VDEPTH];
  logic [31:0]    mem_next  [VDEPTH];
  logic [31:0]    mem_decii [VDEPTH];
  logic [AXW-1:0] mem_delta [VDEPTH][NAXES];
  logic [31:0]    rep_cnt   [VDEPTH];

  logic [VADR_W-1:0]            pc, pc_n;
  logic [31:0]                  idx, idx_n, sub, sub_n, dec, dec_n;
  logic [NAXES-1:0][AXW-1:0]    acc, acc_n;
  logic [TIMEW-1:0]             time_q, time_n;
  logic [31:0]                  opt_q, opt_n;
  logic [1:0]                   store_q, store_n;
  logic                         setvec_q, rep_dec, rep_rearm;
  logic [32:0]                  tgt;
  logic [VADR_W-1:0]            wadr;
  logic                         unused_vadr;

  always_comb begin
    for (int i = 0; i < NW; i++) w[i] = bus.vp_set[32*i +: 32];
  end

  assign wadr        = w[0][VADR_W-1:0];
  assign unused_vadr = ^w[0][31:VADR_W];

  function automatic logic [AXW-1:0] acc_add(input logic [AXW-1:0] a, input logic [AXW-1:0] d);
    logic [AXW-1:0] s;
    s = a + d;
`ifdef GVP_ND_SATURATE_EN
    if (a[AXW-1] == d[AXW-1] && s[AXW-1] != a[AXW-1])
      s = a[AXW-1] ? {1'b1, {(AXW-1){1'b0}}} : {1'b0, {(AXW-1){1'b1}}};
`endif
    return s;
  endfunction

  // Vector memory and repeat counters survive reset so a program can be rerun.
  always_ff @(posedge a_clk) begin
    setvec_q <= bus.setvec;
    if (reset && bus.setvec && !setvec_q) begin
      mem_n[wadr]     <= w[1];
      mem_nii[wadr]   <= w[2];
      mem_opt[wadr]   <= w[3];
      mem_nrep[wadr]  <= w[4];
      mem_next[wadr]  <= w[5];
      mem_decii[wadr] <= w[6+NAXES];
      rep_cnt[wadr]   <= w[4];
      for (int k = 0; k < NAXES; k++) mem_delta[wadr][k] <= AXW'($signed(w[6+k]));
    end else if (!reset) begin
      if (rep_dec)        rep_cnt[pc] <= rep_cnt[pc] - 32'd1;
      else if (rep_rearm) rep_cnt[pc] <= mem_nrep[pc];
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    idx_n     = idx;
    sub_n     = sub;
    dec_n     = dec;
    acc_n     = acc;
    time_n    = time_q;
    opt_n     = opt_q;
    store_n   = store_q;
    rep_dec   = 1'b0;
    rep_rearm = 1'b0;
    tgt       = '0;
    // While paused a pending strobe is held in store_q and only masked at the output.
    if (!bus.pause) begin
      store_n = 2'd0;
      if (state != FIN) time_n = time_q + TIMEW'(1);
      case (state)
        IDLE: begin
          pc_n    = '0;
          state_n = LOAD;
        end
        LOAD: begin
          if (mem_n[pc] == 32'd0) begin
            state_n = FIN;
          end else begin
            idx_n   = mem_n[pc] - 32'd1;
            sub_n   = mem_nii[pc];
            dec_n   = mem_decii[pc];
            opt_n   = mem_opt[pc];
            store_n = 2'd2;
            state_n = HDR;
          end
        end
        HDR, STEP: begin
          state_n = STEP;
          if (dec != 32'd0) begin
            dec_n = dec - 32'd1;
          end else begin
            for (int k = 0; k < NAXES; k++) acc_n[k] = acc_add(acc[k], mem_delta[pc][k]);
            dec_n = mem_decii[pc];
            if (sub != 32'd0) begin
              sub_n = sub - 32'd1;
            end else begin
              store_n = 2'd1;
              sub_n   = mem_nii[pc];
              if (idx != 32'd0) begin
                idx_n = idx - 32'd1;
              end else begin
                // Any set bit above the address width means pc left the table.
                if (mem_next[pc] != 32'd0 && rep_cnt[pc] != 32'd0) begin
                  rep_dec = 1'b1;
                  tgt = {{(33-VADR_W){1'b0}}, pc} + {mem_next[pc][31], mem_next[pc]};
                end else begin
                  rep_rearm = 1'b1;
                  tgt = {{(33-VADR_W){1'b0}}, pc} + 33'd1;
                end
                if (tgt[32:VADR_W] != '0) begin
                  state_n = FIN;
                end else begin
                  pc_n    = tgt[VADR_W-1:0];
                  state_n = LOAD;
                end
              end
            end
          end
        end
        default: state_n = FIN;
      endcase
    end
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      idx     <= '0;
      sub     <= '0;
      dec     <= '0;
      acc     <= '0;
      time_q  <= '0;
      opt_q   <= bus.reset_options;
      store_q <= 2'd0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      idx     <= idx_n;
      sub     <= sub_n;
      dec     <= dec_n;
      acc     <= acc_n;
      time_q  <= time_n;
      opt_q   <= opt_n;
      store_q <= store_n;
    end
  end

  assign bus.M_AXIS_tdata          = acc;
  assign bus.M_AXIS_tvalid         = (state == LOAD) || (state == HDR) || (state == STEP);
  assign bus.M_AXIS_index_tdata    = idx;
  assign bus.M_AXIS_gvp_time_tdata = time_q;
  assign bus.options               = (state == IDLE || state == FIN) ? bus.reset_options : opt_q;
  assign bus.store_data            = bus.pause ? 2'd0 : store_q;
  assign bus.gvp_finished          = (state == FIN);
  assign bus.dbg_state             = state;
endmodule

// File: tb/tb_gvp_nd.sv
// Directed bench for gvp_nd: ramp, decimation, nested loops, pause, mid-run reset, overflow.
module tb_gvp_nd;
  localparam int NAXES = 6, AXW = 32, VADR_W = 4, TIMEW = 48;

  logic a_clk = 1'b0;
  logic reset = 1'b1;
  always #5 a_clk = ~a_clk;

  gvp_nd_if #(.NAXES(NAXES), .AXW(AXW), .TIMEW(TIMEW)) bus ();
  gvp_nd #(.NAXES(NAXES), .AXW(AXW), .VADR_W(VADR_W), .TIMEW(TIMEW)) dut (
    .a_clk(a_clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  int hdr_cnt, pt_cnt, fin_clk, first_hdr, first_pt, gap_bad;
  logic [63:0] hdr_idx, hdr_opt, hdr_valid, hdr_time, pt_idx, paused_acc, paused_time;

  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AXW-1:0] acc_of(input int k);
    return bus.M_AXIS_tdata[k*AXW +: AXW];
  endfunction

  task automatic write_vec(input int adr, input int n, input int nii, input int opt,
                           input int nrep, input int nxt, input int ax,
                           input logic [31:0] d, input int decii);
    logic [32*(7+NAXES)-1:0] v;
    v = '0;
    v[0 +: 32]              = adr;
    v[32 +: 32]             = n;
    v[64 +: 32]             = nii;
    v[96 +: 32]             = opt;
    v[128 +: 32]            = nrep;
    v[160 +: 32]            = nxt;
    v[32*(6+ax) +: 32]      = d;
    v[32*(6+NAXES) +: 32]   = decii;
    bus.vp_set = v;
    bus.setvec = 1'b1;
    tick();
    bus.setvec = 1'b0;
    tick();
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    tick();
    tick();
  endtask

  // Releases reset and samples every clock; clock 1 is the first edge that sees reset=0.
  task automatic run_prog(input int max_clk, input int exp_gap, input int p_at,
                          input int p_len, input int abort_at);
    int prev;
    hdr_cnt = 0; pt_cnt = 0; fin_clk = -1; first_hdr = -1; first_pt = -1;
    gap_bad = 0; prev = -1;
    reset = 1'b0;
    for (int c = 1; c <= max_clk; c++) begin
      tick();
      if (bus.store_data == 2'd2) begin
        hdr_cnt++;
        if (first_hdr < 0) begin
          first_hdr = c;
          hdr_idx   = 64'(bus.M_AXIS_index_tdata);
          hdr_opt   = 64'(bus.options);
          hdr_valid = 64'(bus.M_AXIS_tvalid);
          hdr_time  = 64'(bus.M_AXIS_gvp_time_tdata);
        end
      end
      if (bus.store_data == 2'd1) begin
        pt_cnt++;
        if (first_pt < 0) begin
          first_pt = c;
          pt_idx   = 64'(bus.M_AXIS_index_tdata);
        end
        if (exp_gap > 0 && prev > 0 && (c - prev) != exp_gap) gap_bad++;
        prev = c;
      end
      if (p_len > 0 && c == p_at) bus.pause = 1'b1;
      if (p_len > 0 && c == p_at + p_len) begin
        paused_acc  = 64'(acc_of(0));
        paused_time = 64'(bus.M_AXIS_gvp_time_tdata);
        bus.pause   = 1'b0;
      end
      if (c == abort_at) return;
      if (bus.gvp_finished) begin
        fin_clk = c;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.setvec        = 1'b0;
    bus.vp_set        = '0;
    bus.reset_options = 32'h11;
    bus.pause         = 1'b0;
    hold_reset();
    tick();

    chk("rst_tdata",  64'(bus.M_AXIS_tdata[63:0]), 64'h0);
    chk("rst_tvalid", 64'(bus.M_AXIS_tvalid), 64'h0);
    chk("rst_time",   64'(bus.M_AXIS_gvp_time_tdata), 64'h0);
    chk("rst_store",  64'(bus.store_data), 64'h0);
    chk("rst_fin",    64'(bus.gvp_finished), 64'h0);
    chk("rst_opt",    64'(bus.options), 64'h11);

    // Basic ramp
    write_vec(0, 5, 2, 32'hA5, 0, 0, 0, 32'd1, 0);
    write_vec(1, 0, 0, 0, 0, 0, 0, 32'd0, 0);
    run_prog(100, 3, 0, 0, 0);
    chk("t1_first_hdr", 64'(first_hdr), 64'd2);
    chk("t1_hdr_cnt",   64'(hdr_cnt), 64'd1);
    chk("t1_hdr_opt",   hdr_opt, 64'hA5);
    chk("t1_hdr_valid", hdr_valid, 64'd1);
    chk("t1_hdr_time",  hdr_time, 64'd2);
    chk("t1_hdr_idx",   hdr_idx, 64'd4);
    chk("t1_first_pt",  64'(first_pt), 64'd5);
    chk("t1_pt_cnt",    64'(pt_cnt), 64'd5);
    chk("t1_gap",       64'(gap_bad), 64'd0);
    chk("t1_fin_clk",   64'(fin_clk), 64'd18);
    chk("t1_acc0",      64'(acc_of(0)), 64'd15);
    chk("t1_time",      64'(bus.M_AXIS_gvp_time_tdata), 64'd18);
    chk("t1_fin_opt",   64'(bus.options), 64'h11);
    chk("t1_fin_valid", 64'(bus.M_AXIS_tvalid), 64'd0);
    tick();
    chk("t1_fin_hold",  64'(bus.gvp_finished), 64'd1);

    // Pause for 10 clocks mid-section of the ramp
    hold_reset();
    run_prog(100, 0, 6, 10, 0);
    chk("t4_paused_acc",  paused_acc, 64'd4);
    chk("t4_paused_time", paused_time, 64'd6);
    chk("t4_pt_cnt",      64'(pt_cnt), 64'd5);
    chk("t4_fin_clk",     64'(fin_clk), 64'd28);
    chk("t4_acc0",        64'(acc_of(0)), 64'd15);
    chk("t4_time",        64'(bus.M_AXIS_gvp_time_tdata), 64'd18);

    // Decimation
    hold_reset();
    write_vec(0, 2, 0, 0, 0, 0, 3, 32'hFFFF_FFFC, 3);
    write_vec(1, 0, 0, 0, 0, 0, 0, 32'd0, 0);
    run_prog(100, 4, 0, 0, 0);
    chk("t2_first_pt", 64'(first_pt), 64'd6);
    chk("t2_pt_cnt",   64'(pt_cnt), 64'd2);
    chk("t2_gap",      64'(gap_bad), 64'd0);
    chk("t2_hdr_idx",  hdr_idx, 64'd1);
    chk("t2_pt_idx",   pt_idx, 64'd0);
    chk("t2_acc3",     64'(acc_of(3)), 64'hFFFF_FFF8);
    chk("t2_fin_clk",  64'(fin_clk), 64'd11);

    // Nested loop: v2 jumps back to v0 three extra times
    hold_reset();
    write_vec(0, 4, 0, 0, 0, 0, 0, 32'd1, 0);
    write_vec(1, 4, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    write_vec(2, 1, 0, 0, 3, -2, 1, 32'd1, 0);
    write_vec(3, 0, 0, 0, 0, 0, 0, 32'd0, 0);
    run_prog(300, 1, 0, 0, 0);
    chk("t3_hdr_cnt", 64'(hdr_cnt), 64'd12);
    chk("t3_pt_cnt",  64'(pt_cnt), 64'd36);
    chk("t3_acc0",    64'(acc_of(0)), 64'd0);
    chk("t3_acc1",    64'(acc_of(1)), 64'd4);
    chk("t3_fin",     64'(bus.gvp_finished), 64'd1);
    hold_reset();
    run_prog(300, 1, 0, 0, 0);
    chk("t3_rerun_hdr", 64'(hdr_cnt), 64'd12);
    chk("t3_rerun_pt",  64'(pt_cnt), 64'd36);
    chk("t3_rerun_acc1", 64'(acc_of(1)), 64'd4);

    // Reset mid-run during section 0
    hold_reset();
    run_prog(6, 0, 0, 0, 6);
    chk("t5_running", 64'(bus.M_AXIS_tvalid), 64'd1);
    reset = 1'b1;
    tick();
    chk("t5_tdata",  64'(bus.M_AXIS_tdata[63:0]), 64'h0);
    chk("t5_tvalid", 64'(bus.M_AXIS_tvalid), 64'd0);
    chk("t5_index",  64'(bus.M_AXIS_index_tdata), 64'd0);
    chk("t5_time",   64'(bus.M_AXIS_gvp_time_tdata), 64'd0);
    chk("t5_store",  64'(bus.store_data), 64'd0);
    chk("t5_opt",    64'(bus.options), 64'h11);
    tick();
    run_prog(300, 1, 0, 0, 0);
    chk("t5_rerun_hdr",  64'(hdr_cnt), 64'd12);
    chk("t5_rerun_pt",   64'(pt_cnt), 64'd36);
    chk("t5_rerun_acc0", 64'(acc_of(0)), 64'd0);
    chk("t5_rerun_acc1", 64'(acc_of(1)), 64'd4);

    // Overflow past the positive limit
    hold_reset();
    write_vec(0, 3, 0, 0, 0, 0, 0, 32'h4000_0000, 0);
    write_vec(1, 0, 0, 0, 0, 0, 0, 32'd0, 0);
    run_prog(100, 1, 0, 0, 0);
`ifdef GVP_ND_SATURATE_EN
    chk("t6_acc0_sat",  64'(acc_of(0)), 64'h7FFF_FFFF);
`else
    chk("t6_acc0_wrap", 64'(acc_of(0)), 64'hC000_0000);
`endif
    chk("t6_pt_cnt", 64'(pt_cnt), 64'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
